// File: rtl/instr_fetch_unit_if.sv
// Purpose: fetch-unit bundle (instruction-memory side plus decode/execute side).
// Latency: none, wires only.
// Backpressure: ImemRdy stalls the fetch; InstrAccept stalls hand-off downstream.
// Ports (master = fetch unit):
//   out: ImemReq, ImemAddr, Instr, InstrValid, PC, PCPlus4, Halted
//   in : ImemRdy, ImemRdata, InstrAccept, Branch, Jump, Zero, SignImm
interface instr_fetch_unit_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemRdy;
  logic [31:0] ImemRdata;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        InstrAccept;
  logic        Branch;
  logic        Jump;
  logic        Zero;
  logic [31:0] SignImm;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Halted;

  modport master (
    output ImemReq, ImemAddr, Instr, InstrValid, PC, PCPlus4, Halted,
    input  ImemRdy, ImemRdata, InstrAccept, Branch, Jump, Zero, SignImm
  );

  modport slave (
    input  ImemReq, ImemAddr, Instr, InstrValid, PC, PCPlus4, Halted,
    output ImemRdy, ImemRdata, InstrAccept, Branch, Jump, Zero, SignImm
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose: MIPS front end; owns PC, fetches a word, holds it for decode, picks NextPC.
// Latency: 2 cycles per instruction minimum (1 request + 1 hand-off), +1 per wait/stall cycle.
// Backpressure: S_REQ waits on ImemRdy; S_VALID holds Instr and PC until InstrAccept.
// Ports: clk (rising edge), rst (async active-low), bus (instr_fetch_unit_if.master).
// Optional: define HALT_EN to stop fetching after accepting a HALT_OPCODE word.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_fetch_unit_if.master     bus
);

`ifdef HALT_EN
  typedef enum logic [1:0] {S_BOOT, S_REQ, S_VALID, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_BOOT, S_REQ, S_VALID} state_e;
`endif

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        vld_q;
  logic [31:0] pc_plus4;
  logic [31:0] jmp_target;
  logic [31:0] br_target;
  logic [31:0] next_pc_d;

  assign pc_plus4   = pc_q + 32'd4;
  assign jmp_target = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  assign br_target  = pc_plus4 + {bus.SignImm[29:0], 2'b00};

  // Jump outranks a taken branch.
  always_comb begin
    next_pc_d = pc_plus4;
    if (bus.Jump) begin
      next_pc_d = jmp_target;
    end else if (bus.Branch && bus.Zero) begin
      next_pc_d = br_target;
    end
  end

`ifdef HALT_EN
  logic halted_q;
`endif

  // ImemReq / InstrValid are registered alongside the state so they never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      req_q    <= 1'b0;
      vld_q    <= 1'b0;
`ifdef HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (bus.ImemRdy) begin
            instr_q <= bus.ImemRdata;
            state_q <= S_VALID;
            req_q   <= 1'b0;
            vld_q   <= 1'b1;
          end
        end
        S_VALID: begin
          if (bus.InstrAccept) begin
            vld_q <= 1'b0;
`ifdef HALT_EN
            // A halt word freezes PC at its own address.
            if (instr_q[31:26] == HALT_OPCODE) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q    <= next_pc_d;
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end
`else
            pc_q    <= next_pc_d;
            state_q <= S_REQ;
            req_q   <= 1'b1;
`endif
          end
        end
        default: begin
          // S_HALT (or unreachable encoding): hold everything until reset.
          state_q <= state_q;
        end
      endcase
    end
  end

  assign bus.ImemReq    = req_q;
  assign bus.ImemAddr   = pc_q;
  assign bus.Instr      = instr_q;
  assign bus.InstrValid = vld_q;
  assign bus.PC         = pc_q;
  assign bus.PCPlus4    = pc_plus4;
`ifdef HALT_EN
  assign bus.Halted     = halted_q;
`else
  assign bus.Halted     = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the single-cycle MIPS core.
- Owns the program counter and fetches 32-bit instruction words from instruction memory over a variable-latency request/ready handshake.
- Presents each held instruction to the downstream decode/execute stage; its opcode field drives the main control decoder.
- Computes the next PC from the control decoder's Branch/Jump outputs and the ALU Zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
HALT_OPCODE, 6'b111111, opcode treated as halt (used only with HALT_EN).

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous active-low reset
ImemReq  output  1  fetch request to instruction memory
ImemAddr  output  32  fetch byte address (equals PC)
ImemRdy  input  1  read data valid this cycle
ImemRdata  input  32  instruction word from memory
Instr  output  32  held instruction
InstrValid  output  1  Instr is valid for downstream
InstrAccept  input  1  downstream consumes Instr this cycle
Branch  input  1  from control decoder
Jump  input  1  from control decoder
Zero  input  1  ALU zero flag
SignImm  input  32  sign-extended immediate
PC  output  32  current program counter
PCPlus4  output  32  PC + 4, combinational
Halted  output  1  halt reached (tied 0 without HALT_EN)

Behaviour:
- Reset (rst=0, async):
  - State=S_BOOT, PC=RESET_PC, Instr=32'h0.
  - ImemReq=0, InstrValid=0, Halted=0.
  - Reset asserted mid-fetch aborts the fetch; any late ImemRdy is ignored.
- States:
  - S_BOOT: ImemReq=0; unconditionally moves to S_REQ on the next edge. Gives one idle cycle after reset release.
  - S_REQ: ImemReq=1, ImemAddr=PC, held stable. If ImemRdy=1: Instr<=ImemRdata and go to S_VALID. Otherwise stay; this covers any number of wait cycles.
  - S_VALID: InstrValid=1, Instr held. If InstrAccept=1: PC<=NextPC and go to S_REQ. Otherwise hold indefinitely.
- Signals ignored by state:
  - ImemRdy and ImemRdata are ignored outside S_REQ.
  - InstrAccept, Branch, Jump, Zero and SignImm are sampled only in S_VALID with InstrAccept=1.
- NextPC priority:
  1. Jump=1 -> {PCPlus4[31:28], Instr[25:0], 2'b00}.
  2. Branch=1 and Zero=1 -> PCPlus4 + (SignImm<<2).
  3. Otherwise -> PCPlus4.
- Arithmetic: 32-bit modulo 2^32. PC 32'hFFFF_FFFC increments to 32'h0; there is no overflow flag.
- Latency and throughput:
  - Minimum is 2 cycles per instruction (ImemRdy=1 in S_REQ, InstrAccept=1 in S_VALID).
  - Each memory wait cycle or downstream stall cycle adds one cycle.
- Outputs: ImemReq and InstrValid are decoded from state only and are glitch-free registered-state functions. PC, ImemAddr and Instr are registered.

Optional Feature:
HALT_EN:
- With the macro defined:
  - If Instr[31:26]==HALT_OPCODE and it is accepted in S_VALID, go to S_HALT and leave PC unchanged.
  - In S_HALT: Halted=1, ImemReq=0, InstrValid=0.
  - S_HALT is left only by reset.
- Without the macro: no S_HALT state, Halted tied 0, HALT_OPCODE is fetched and handed downstream like any other word.

Test Plan:
1. RESET_PC=32'h0040_0000, release rst -> cycle 1: ImemReq=0. Cycle 2: ImemReq=1, ImemAddr=32'h0040_0000, InstrValid=0.
2. ImemRdy and InstrAccept always 1, no branch or jump -> ImemAddr sequence 0x0, 0x4, 0x8, one new address every 2 cycles. Instr matches memory contents.
3. ImemRdy low for 3 cycles in S_REQ -> ImemAddr stable for 4 cycles, InstrValid=0. Then InstrAccept low for 2 cycles -> Instr and PC unchanged.
4. Branch at PC=0x10:
   - Branch=1, Zero=1, SignImm=32'hFFFF_FFFE -> next ImemAddr=0x0C.
   - Same with Zero=0 -> 0x14.
5. Jump at PC=32'h3000_0020 with Instr[25:0]=26'h100 -> next address 32'h3000_0400. With Jump=1, Branch=1 and Zero=1 together -> jump target wins.
6. Two reset/halt cases:
   - Assert rst during S_REQ wait, then pulse ImemRdy -> PC=RESET_PC and ImemRdy ignored.
   - With HALT_EN, accept opcode 6'b111111 -> Halted=1 and ImemReq stays 0 for 10+ cycles.
